// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Bundles the FIFO read port and the downstream valid/ready stream of the
// FIFO stream reader.
//   fifo_empty  FIFO empty flag                      (FIFO -> reader)
//   fifo_rdata  FIFO registered read data            (FIFO -> reader)
//   fifo_cs     FIFO chip select                     (reader -> FIFO)
//   fifo_rd_en  FIFO read request                    (reader -> FIFO)
//   m_valid     stream data valid                    (reader -> sink)
//   m_data      stream data                          (reader -> sink)
//   m_ready     sink accepts                         (sink -> reader)
// master: the reader side. slave: the FIFO plus stream sink side.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_cs;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_cs,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_cs,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a synchronous FIFO (one-cycle registered read data) onto a
// valid/ready stream. A two-entry buffer absorbs the read latency so one word
// per cycle flows with no backpressure, and no word is lost or duplicated
// under arbitrary backpressure.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   en_i        read enable; low blocks new FIFO reads, buffered data still drains
//   bus         fifo_stream_reader_if.master (FIFO read port + output stream)
//   rd_count_o  number of delivered words, wraps modulo 2^CNT_WIDTH
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] rd_count_o
);

    logic [1:0]            occ_q, occ_d, occ_pop;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            pending;
    logic                  pop;
    logic                  room;
    logic                  issue;

    assign pop     = (occ_q != 2'd0) && bus.m_ready;
    // Words already committed to the buffer: held plus the one arriving now.
    assign pending = occ_q + {1'b0, inflight_q};
    assign room    = (pending < 2'd2);
    // The pop term lets a read go out in the same cycle a full buffer drains,
    // so releasing backpressure does not create a bubble.
    assign issue   = !rst && en_i && !bus.fifo_empty && (room || pop);

    assign bus.fifo_rd_en = issue;
    assign bus.fifo_cs    = issue;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = buf_q[0];
    assign rd_count_o     = cnt_q;

    always_comb begin
        buf_d      = buf_q;
        occ_pop    = occ_q - {1'b0, pop};
        occ_d      = occ_pop;
        inflight_d = issue;
        cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        // Pop first so the capture lands directly behind the surviving head.
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (inflight_q) begin
            buf_d[occ_pop[0]] = bus.fifo_rdata;
            occ_d             = occ_pop + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
        end
    end

    // A capture into a full buffer would overwrite an undelivered word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_check: assert (!(inflight_q && occ_pop == 2'd2));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    localparam int DW = 32;

    typedef struct {
        int unsigned n_words;
        int unsigned mode;      // 0: ready high, 1: ready toggles, 2: random ready
        int unsigned en_gap;    // reads after which en drops for 4 cycles, 0 = never
        logic [31:0] base;
        int unsigned exp_count; // rd_count after the scenario drains
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus4 ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .bus        (bus),
        .rd_count_o (rd_count)
    );

    // Narrow-counter twin sees identical inputs, so it behaves identically.
    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .bus        (bus4),
        .rd_count_o (rd_count4)
    );

    assign bus4.fifo_empty = bus.fifo_empty;
    assign bus4.fifo_rdata = bus.fifo_rdata;
    assign bus4.m_ready    = bus.m_ready;

    // FIFO model
    logic [DW-1:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [DW-1:0] exp_q [$];

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_rdata <= mem[rd_ptr % 1024];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    // Monitor: scoreboard, count, stability and outstanding-read checks.
    int os = 0;
    int pops = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic monitor_step();
        bit pop;
        logic [DW-1:0] e;
        if (rst) begin
            os = 0;
            pops = 0;
            prev_stall = 1'b0;
        end else begin
            pop = bus.m_valid && bus.m_ready;
            check(bus.fifo_cs === bus.fifo_rd_en, "cs_eq_rd_en", 64'(bus.fifo_cs),
                  64'(bus.fifo_rd_en));
            if (bus.fifo_rd_en) begin
                check(!bus.fifo_empty, "rd_while_empty", 64'(bus.fifo_empty), 64'd0);
            end
            check(rd_count == pops[15:0], "rd_count", 64'(rd_count), 64'(pops[15:0]));
            check(rd_count4 == pops[3:0], "rd_count4", 64'(rd_count4), 64'(pops[3:0]));
            if (prev_stall) begin
                check(bus.m_valid && bus.m_data == prev_data, "hold_stable",
                      64'(bus.m_data), 64'(prev_data));
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "extra_word", 64'(bus.m_data), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.m_data == e, "order", 64'(bus.m_data), 64'(e));
                end
                pops++;
            end
            os = os + (bus.fifo_rd_en ? 1 : 0) - (pop ? 1 : 0);
            check(os >= 0 && os <= 2, "outstanding", 64'(os), 64'd2);
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic wait_drain(input string name);
        int cyc;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.fifo_empty && !bus.m_valid) break;
        end
        if (cyc == 300) check(1'b0, name, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int reads = 0;
        int hold = -1;
        int cyc;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            #1;
            case (v.mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ((cyc % 2) == 0);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.en_gap != 0 && reads >= int'(v.en_gap) && hold < 0) hold = 4;
            if (hold > 0) begin
                en = 1'b0;
                hold--;
            end else begin
                en = 1'b1;
            end
            if (cyc == 0) begin
                for (int i = 0; i < int'(v.n_words); i++) fifo_write(v.base + 32'(i));
            end
            @(negedge clk);
            if (!en) check(!bus.fifo_rd_en, "en_gate", 64'(bus.fifo_rd_en), 64'd0);
            if (bus.fifo_rd_en) reads++;
            if (cyc > 0 && exp_q.size() == 0 && bus.fifo_empty && !bus.m_valid) break;
        end
        if (cyc == 300) check(1'b0, "vec_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        en = 1'b1;
        @(negedge clk);
        check(reads == int'(v.n_words), "vec_reads", 64'(reads), 64'(v.n_words));
        check(rd_count == v.exp_count[15:0], "vec_count", 64'(rd_count), 64'(v.exp_count));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vec_t vecs [3];
        bit [5:0] ev_valid;
        bit [5:0] ev_rd;
        int pulses;

        vecs[0] = '{n_words: 8, mode: 1, en_gap: 0, base: 32'h100, exp_count: 19};
        vecs[1] = '{n_words: 8, mode: 0, en_gap: 3, base: 32'h200, exp_count: 27};
        vecs[2] = '{n_words: 8, mode: 2, en_gap: 0, base: 32'h300, exp_count: 35};

        bus.m_ready = 1'b1;
        en = 1'b1;
        // A word present during reset must not be read; the FIFO discards it.
        mem[wr_ptr % 1024] = 32'hdead;
        wr_ptr++;
        repeat (2) @(negedge clk);
        check(!bus.fifo_rd_en, "rd_en_in_reset", 64'(bus.fifo_rd_en), 64'd0);
        check(!bus.m_valid, "reset_valid", 64'(bus.m_valid), 64'd0);
        check(bus.m_data == '0, "reset_data", 64'(bus.m_data), 64'd0);
        check(rd_count == 16'd0, "reset_count", 64'(rd_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(bus.fifo_empty && !bus.fifo_rd_en, "post_reset_idle", 64'(bus.fifo_rd_en), 64'd0);

        // First-word latency and back-to-back delivery.
        @(posedge clk);
        #1;
        fifo_write(32'd1);
        fifo_write(32'd10);
        fifo_write(32'd100);
        ev_valid = 6'b011100;
        ev_rd    = 6'b000111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(bus.m_valid == ev_valid[k], "lat_valid", 64'(bus.m_valid), 64'(ev_valid[k]));
            check(bus.fifo_rd_en == ev_rd[k], "lat_rd_en", 64'(bus.fifo_rd_en), 64'(ev_rd[k]));
        end
        check(rd_count == 16'd3, "lat_count", 64'(rd_count), 64'd3);

        // Backpressure: only two reads outstanding, head held.
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(32'(1) << i);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) pulses++;
        end
        check(pulses == 2, "bp_pulses", 64'(pulses), 64'd2);
        check(bus.m_valid && bus.m_data == 32'd1, "bp_head", 64'(bus.m_data), 64'd1);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check(bus.m_valid && bus.m_data == (32'(1) << k), "bp_release",
                  64'(bus.m_data), 64'(32'(1) << k));
        end
        @(negedge clk);
        check(!bus.m_valid, "bp_drained", 64'(bus.m_valid), 64'd0);
        check(rd_count == 16'd11, "bp_count", 64'(rd_count), 64'd11);

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Mid-stream reset with a full buffer.
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(32'h400 + 32'(i));
        repeat (4) @(negedge clk);
        check(bus.m_valid && bus.m_data == 32'h400, "rst_pre_head", 64'(bus.m_data), 64'h400);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check(!bus.fifo_rd_en, "rd_en_in_rst", 64'(bus.fifo_rd_en), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(!bus.m_valid, "rst_valid", 64'(bus.m_valid), 64'd0);
            check(!bus.fifo_rd_en, "rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
            check(rd_count == 16'd0, "rst_count", 64'(rd_count), 64'd0);
        end
        @(posedge clk);
        #1;
        fifo_write(32'd77);
        wait_drain("rst_resume_timeout");
        check(rd_count == 16'd1, "rst_resume_count", 64'(rd_count), 64'd1);

        // Counter wrap on the 4-bit twin.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) fifo_write(32'h500 + 32'(i));
        wait_drain("wrap_timeout");
        check(rd_count == 16'd17, "wrap_count16", 64'(rd_count), 64'd17);
        check(rd_count4 == 4'd1, "wrap_count4", 64'(rd_count4), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
